// File: rtl/csi2_packet_parser.sv
// Single-lane MIPI CSI-2 packet parser: decodes short/long packet headers, checks the
// payload CRC-16 and emits sync pulses plus a registered pixel-byte stream.
module csi2_packet_parser #(
    parameter logic [1:0]  VC_ID  = 2'd0,
    parameter logic [15:0] MAX_WC = 16'd4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        sot,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic        pkt_done,
    output logic        crc_err,
    output logic        pkt_err,
    output logic [15:0] line_count,
    output logic [15:0] frame_count
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WCL     = 3'd1;
    localparam logic [2:0] S_WCH     = 3'd2;
    localparam logic [2:0] S_ECC     = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_CRCL    = 3'd5;
    localparam logic [2:0] S_CRCH    = 3'd6;

    logic [2:0]  state, state_nxt;
    logic [1:0]  vc, vc_nxt;
    logic [5:0]  dt, dt_nxt;
    logic [15:0] wc, wc_nxt;        // header WC, then remaining payload bytes
    logic [15:0] crc, crc_nxt;
    logic [7:0]  crc_lo, crc_lo_nxt;

    logic [7:0]  pix_data_nxt;
    logic        pix_valid_nxt;
    logic [5:0]  data_type_nxt;
    logic [15:0] word_count_nxt;
    logic        frame_start_nxt, frame_end_nxt, line_start_nxt, line_end_nxt;
    logic        pkt_done_nxt, crc_err_nxt, pkt_err_nxt;
    logic [15:0] line_count_nxt, frame_count_nxt;

    logic vc_match;
    assign vc_match = (vc == VC_ID);

    // One byte of the reflected CCITT CRC, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        vc_nxt          = vc;
        dt_nxt          = dt;
        wc_nxt          = wc;
        crc_nxt         = crc;
        crc_lo_nxt      = crc_lo;
        pix_data_nxt    = pix_data;
        pix_valid_nxt   = 1'b0;
        data_type_nxt   = data_type;
        word_count_nxt  = word_count;
        frame_start_nxt = 1'b0;
        frame_end_nxt   = 1'b0;
        line_start_nxt  = 1'b0;
        line_end_nxt    = 1'b0;
        pkt_done_nxt    = 1'b0;
        crc_err_nxt     = 1'b0;
        pkt_err_nxt     = 1'b0;
        line_count_nxt  = line_count;
        frame_count_nxt = frame_count;

        if (!enable) begin
            state_nxt = S_IDLE;
        end else if (!byte_valid) begin
            if (state != S_IDLE) begin
                pkt_err_nxt = 1'b1;
                state_nxt   = S_IDLE;
            end
        end else if (sot) begin
            // A DI byte restarts parsing; arriving mid-packet it also flags the abort.
            pkt_err_nxt = (state != S_IDLE);
            vc_nxt      = byte_in[7:6];
            dt_nxt      = byte_in[5:0];
            crc_nxt     = 16'hFFFF;
            state_nxt   = S_WCL;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_IDLE;
                S_WCL: begin
                    wc_nxt[7:0] = byte_in;
                    state_nxt   = S_WCH;
                end
                S_WCH: begin
                    wc_nxt[15:8] = byte_in;
                    if (vc_match) begin
                        data_type_nxt  = dt;
                        word_count_nxt = {byte_in, wc[7:0]};
                    end
                    state_nxt = S_ECC;
                end
                S_ECC: begin
                    if (dt <= 6'h0F) begin
                        if (vc_match) begin
                            frame_start_nxt = (dt == 6'h00);
                            frame_end_nxt   = (dt == 6'h01);
                            line_start_nxt  = (dt == 6'h02);
                            line_end_nxt    = (dt == 6'h03);
                            if (dt == 6'h00) begin
                                line_count_nxt  = 16'd0;
                                frame_count_nxt = frame_count + 16'd1;
                            end
                        end
                        state_nxt = S_IDLE;
                    end else if (wc > MAX_WC) begin
                        pkt_err_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end else if (wc == 16'd0) begin
                        state_nxt = S_CRCL;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (vc_match) begin
                        pix_data_nxt  = byte_in;
                        pix_valid_nxt = 1'b1;
                    end
                    crc_nxt = crc16_byte(crc, byte_in);
                    wc_nxt  = wc - 16'd1;
                    if (wc == 16'd1) state_nxt = S_CRCL;
                end
                S_CRCL: begin
                    crc_lo_nxt = byte_in;
                    state_nxt  = S_CRCH;
                end
                S_CRCH: begin
                    if (vc_match) begin
                        pkt_done_nxt = 1'b1;
                        crc_err_nxt  = ({byte_in, crc_lo} != crc);
                        if (line_count != 16'hFFFF) line_count_nxt = line_count + 16'd1;
                    end
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            vc          <= 2'd0;
            dt          <= 6'd0;
            wc          <= 16'd0;
            crc         <= 16'hFFFF;
            crc_lo      <= 8'd0;
            pix_data    <= 8'd0;
            pix_valid   <= 1'b0;
            data_type   <= 6'd0;
            word_count  <= 16'd0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            pkt_done    <= 1'b0;
            crc_err     <= 1'b0;
            pkt_err     <= 1'b0;
            line_count  <= 16'd0;
            frame_count <= 16'd0;
        end else begin
            state       <= state_nxt;
            vc          <= vc_nxt;
            dt          <= dt_nxt;
            wc          <= wc_nxt;
            crc         <= crc_nxt;
            crc_lo      <= crc_lo_nxt;
            pix_data    <= pix_data_nxt;
            pix_valid   <= pix_valid_nxt;
            data_type   <= data_type_nxt;
            word_count  <= word_count_nxt;
            frame_start <= frame_start_nxt;
            frame_end   <= frame_end_nxt;
            line_start  <= line_start_nxt;
            line_end    <= line_end_nxt;
            pkt_done    <= pkt_done_nxt;
            crc_err     <= crc_err_nxt;
            pkt_err     <= pkt_err_nxt;
            line_count  <= line_count_nxt;
            frame_count <= frame_count_nxt;
        end
    end
endmodule

// File: tb/tb_csi2_packet_parser.sv
// Bench for csi2_packet_parser: packet-level model predicts every output each cycle.
module tb_csi2_packet_parser;
    localparam logic [1:0]  VC_ID  = 2'd0;
    localparam logic [15:0] MAX_WC = 16'd4096;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        sot = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [5:0]  data_type;
    logic [15:0] word_count;
    logic        frame_start, frame_end, line_start, line_end;
    logic        pkt_done, crc_err, pkt_err;
    logic [15:0] line_count, frame_count;

    always #5 clk = ~clk;

    csi2_packet_parser #(.VC_ID(VC_ID), .MAX_WC(MAX_WC)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .byte_in(byte_in),
        .byte_valid(byte_valid), .sot(sot), .pix_data(pix_data), .pix_valid(pix_valid),
        .data_type(data_type), .word_count(word_count), .frame_start(frame_start),
        .frame_end(frame_end), .line_start(line_start), .line_end(line_end),
        .pkt_done(pkt_done), .crc_err(crc_err), .pkt_err(pkt_err),
        .line_count(line_count), .frame_count(frame_count)
    );

    typedef struct packed {
        logic        pv;
        logic [7:0]  pd;
        logic        fs, fe, ls, le, done, cerr, perr;
        logic [5:0]  dt;
        logic [15:0] wc, lc, fc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [5:0]  m_dt = '0;
    logic [15:0] m_wc = '0, m_lc = '0, m_fc = '0;
    logic [7:0]  m_pd = '0;
    logic        pend_err = 1'b0;
    logic [7:0]  pay[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [15:0] crc16_model(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ 16'(d);
        repeat (8) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e    = '0;
        e.pd = m_pd;
        e.dt = m_dt;
        e.wc = m_wc;
        e.lc = m_lc;
        e.fc = m_fc;
        return e;
    endfunction

    // Apply one byte at the falling edge; e is what the outputs must show after the next rising edge.
    task automatic drive(input logic en, input logic v, input logic s, input logic [7:0] b, input exp_t e);
        @(negedge clk);
        enable = en; byte_valid = v; sot = s; byte_in = b;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'h00, idle_exp());
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    // abort_mode: 0 none, 1 byte_valid drop at stop_at, 2 next packet's sot interrupts, 3 just stop
    task automatic send_packet(input logic en, input logic [1:0] vc, input logic [5:0] dt,
                               input logic [15:0] wc, input int stop_at, input int abort_mode,
                               input logic [15:0] crc_tx);
        exp_t        e;
        logic        vm;
        logic [15:0] crc_m;
        vm = en && (vc == VC_ID);
        e = idle_exp();
        e.perr = pend_err && en;
        pend_err = 1'b0;
        drive(en, 1'b1, 1'b1, {vc, dt}, e);
        drive(en, 1'b1, 1'b0, wc[7:0], idle_exp());
        if (vm) begin m_dt = dt; m_wc = wc; end
        drive(en, 1'b1, 1'b0, wc[15:8], idle_exp());
        if (dt <= 6'h0F) begin
            if (vm && dt == 6'h00) begin m_lc = 16'd0; m_fc = m_fc + 16'd1; end
            e = idle_exp();
            if (vm) begin
                e.fs = (dt == 6'h00); e.fe = (dt == 6'h01);
                e.ls = (dt == 6'h02); e.le = (dt == 6'h03);
            end
            drive(en, 1'b1, 1'b0, 8'h3C, e);
            return;
        end
        if (wc > MAX_WC) begin
            e = idle_exp();
            e.perr = en;
            drive(en, 1'b1, 1'b0, 8'h3C, e);
            return;
        end
        drive(en, 1'b1, 1'b0, 8'h3C, idle_exp());
        crc_m = 16'hFFFF;
        for (int i = 0; i < int'(wc); i++) begin
            if (i == stop_at) begin
                if (abort_mode == 1) begin
                    e = idle_exp();
                    e.perr = en;
                    drive(en, 1'b0, 1'b0, 8'h00, e);
                end else if (abort_mode == 2) begin
                    pend_err = 1'b1;
                end
                return;
            end
            crc_m = crc16_model(crc_m, pay[i]);
            if (vm) m_pd = pay[i];
            e = idle_exp();
            e.pv = vm;
            drive(en, 1'b1, 1'b0, pay[i], e);
        end
        drive(en, 1'b1, 1'b0, crc_tx[7:0], idle_exp());
        if (vm && m_lc != 16'hFFFF) m_lc = m_lc + 16'd1;
        e = idle_exp();
        e.done = vm;
        e.cerr = vm && (crc_tx != crc_m);
        drive(en, 1'b1, 1'b0, crc_tx[15:8], e);
    endtask

    // Compare process: every driven cycle has one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pix_valid",   16'(pix_valid),   16'(e.pv));
                chk("pix_data",    16'(pix_data),    16'(e.pd));
                chk("frame_start", 16'(frame_start), 16'(e.fs));
                chk("frame_end",   16'(frame_end),   16'(e.fe));
                chk("line_start",  16'(line_start),  16'(e.ls));
                chk("line_end",    16'(line_end),    16'(e.le));
                chk("pkt_done",    16'(pkt_done),    16'(e.done));
                chk("crc_err",     16'(crc_err),     16'(e.cerr));
                chk("pkt_err",     16'(pkt_err),     16'(e.perr));
                chk("data_type",   16'(data_type),   16'(e.dt));
                chk("word_count",  word_count,       e.wc);
                chk("line_count",  line_count,       e.lc);
                chk("frame_count", frame_count,      e.fc);
            end
        end
    end

    initial begin
        logic [7:0]  vec[24];
        logic [15:0] c;
        vec = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
                8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        foreach (vec[i]) pay.push_back(vec[i]);
        c = 16'hFFFF;
        foreach (vec[i]) c = crc16_model(c, vec[i]);
        chk("model_crc_pin", c, 16'h00F0);

        // reset state
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, idle_exp());
        drain();
        chk("rst_pix_valid", 16'(pix_valid), 16'h0000);
        chk("rst_frame_count", frame_count, 16'h0000);
        rstn = 1'b1;
        idle(2);

        // frame start / frame end
        send_packet(1'b1, 2'd0, 6'h00, 16'h0000, -1, 0, 16'h0000);
        send_packet(1'b1, 2'd0, 6'h01, 16'h0000, -1, 0, 16'h0000);
        idle(1);
        drain();
        chk("fs_frame_count", frame_count, 16'd1);
        chk("fs_line_count", line_count, 16'd0);

        // good RAW8 line, then the same line with a corrupted CRC
        send_packet(1'b1, 2'd0, 6'h2B, 16'd24, -1, 0, 16'h00F0);
        idle(1);
        drain();
        chk("long_line_count", line_count, 16'd1);
        chk("long_data_type", 16'(data_type), 16'h002B);
        chk("long_word_count", word_count, 16'h0018);
        send_packet(1'b1, 2'd0, 6'h2B, 16'd24, -1, 0, 16'h00F1);
        idle(1);

        // EoT after payload byte 10, then a clean packet
        send_packet(1'b1, 2'd0, 6'h2B, 16'd24, 10, 1, 16'h00F0);
        idle(1);
        send_packet(1'b1, 2'd0, 6'h2B, 16'd24, -1, 0, 16'h00F0);
        idle(1);
        drain();
        chk("abort_line_count", line_count, 16'd3);

        // foreign VC, oversize WC, zero-length long packet
        send_packet(1'b1, 2'd1, 6'h2B, 16'd24, -1, 0, 16'h00F0);
        idle(1);
        send_packet(1'b1, 2'd0, 6'h2B, 16'h2000, -1, 0, 16'h0000);
        idle(1);
        send_packet(1'b1, 2'd0, 6'h2A, 16'h0000, -1, 0, 16'hFFFF);
        idle(1);

        // sot interrupts a payload; the interrupting FS is parsed
        send_packet(1'b1, 2'd0, 6'h2B, 16'd24, 7, 2, 16'h00F0);
        send_packet(1'b1, 2'd0, 6'h00, 16'h0000, -1, 0, 16'h0000);
        idle(1);

        // disabled parser ignores a frame start; other short packet types
        send_packet(1'b0, 2'd0, 6'h00, 16'h0000, -1, 0, 16'h0000);
        idle(1);
        send_packet(1'b1, 2'd0, 6'h05, 16'h1234, -1, 0, 16'h0000);
        send_packet(1'b1, 2'd0, 6'h02, 16'h0001, -1, 0, 16'h0000);
        send_packet(1'b1, 2'd0, 6'h03, 16'h0001, -1, 0, 16'h0000);
        idle(1);
        drain();
        chk("late_frame_count", frame_count, 16'd2);

        // asynchronous reset in the middle of a payload
        send_packet(1'b1, 2'd0, 6'h2B, 16'd24, 5, 3, 16'h0000);
        drain();
        chk("pre_rst_pix_valid", 16'(pix_valid), 16'h0001);
        rstn = 1'b0;
        #1;
        chk("mid_rst_pix_valid", 16'(pix_valid), 16'h0000);
        chk("mid_rst_pix_data", 16'(pix_data), 16'h0000);
        chk("mid_rst_data_type", 16'(data_type), 16'h0000);
        chk("mid_rst_word_count", word_count, 16'h0000);
        chk("mid_rst_frame_count", frame_count, 16'h0000);
        m_dt = '0; m_wc = '0; m_lc = '0; m_fc = '0; m_pd = '0; pend_err = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h11, idle_exp());
        drive(1'b1, 1'b0, 1'b0, 8'h00, idle_exp());
        rstn = 1'b1;
        idle(2);
        send_packet(1'b1, 2'd0, 6'h00, 16'h0000, -1, 0, 16'h0000);
        idle(2);
        drain();
        chk("post_rst_frame_count", frame_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/csi2_packet_parser.md
Name: csi2_packet_parser

Overview:
- Downstream of the OV5647 configuration controller. Consumes the byte-aligned single-lane MIPI CSI-2 stream from the D-PHY byte aligner once sensor configuration has finished.
- Parses short and long packet headers and checks the payload CRC-16.
- Emits frame/line sync pulses plus a registered pixel-byte stream for the RAW unpacker.

Parameters:
- VC_ID, 2'd0: virtual channel accepted. Packets on other VCs are parsed but produce no outputs.
- MAX_WC, 16'd4096: largest legal long-packet word count. Larger values are a packet error.

Ports:
- clk  input  1  system clock, byte clock domain
- rstn  input  1  asynchronous active-low reset
- enable  input  1  tie to controller config_finished. While low, input is ignored and the parser is held in IDLE.
- byte_in  input  8  received HS byte
- byte_valid  input  1  byte_in is valid. A deassertion inside a packet means EoT/abort.
- sot  input  1  pulse with the first byte (DI) of a packet. Ignored unless byte_valid=1.
- pix_data  output  8  payload byte
- pix_valid  output  1  pix_data valid
- data_type  output  6  DT of the current or last packet, held
- word_count  output  16  WC of the current or last packet, held
- frame_start  output  1  1-cycle pulse, DT 0x00
- frame_end  output  1  1-cycle pulse, DT 0x01
- line_start  output  1  1-cycle pulse, DT 0x02
- line_end  output  1  1-cycle pulse, DT 0x03
- pkt_done  output  1  1-cycle pulse after a long packet's second CRC byte
- crc_err  output  1  valid with pkt_done; 1 = received CRC differs from computed
- pkt_err  output  1  1-cycle pulse on abort, early EoT, or WC>MAX_WC
- line_count  output  16  long packets seen since the last frame_start
- frame_count  output  16  frame_start count, wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs 0. State = IDLE. CRC register = 16'hFFFF.
- A byte is accepted when enable=1 and byte_valid=1.

State machine: IDLE -> DI -> WCL -> WCH -> ECC -> {IDLE | PAYLOAD | CRCL} -> CRCH -> IDLE.
- IDLE: an accepted byte with sot=1 is the DI byte. Latch VC=byte[7:6] and DT=byte[5:0], go to WCL. Bytes without sot are dropped.
- WCL and WCH: capture WC little-endian (low byte first).
- ECC: byte consumed, not checked.
- Short packet (DT<=0x0F): on the cycle after the ECC byte, pulse the matching sync output if VC matches, then go to IDLE. DT 0x04..0x0F: no pulse.
- Long packet with WC>MAX_WC: pkt_err the cycle after the ECC byte, then IDLE.
- Long packet with WC=0: go to CRCL.
- Long packet otherwise: go to PAYLOAD and down-count the remaining bytes. The last payload byte moves to CRCL.
- CRCL and CRCH: receive the CRC, low byte first.

Data path and timing:
- PAYLOAD: pix_data/pix_valid are registered, 1-cycle latency from byte_in, and qualified by VC match.
- data_type and word_count update 1 cycle after the WCH byte.

CRC-16 (payload bytes only):
- Reflected polynomial 0x8408 (x^16+x^12+x^5+1), LSB-first.
- Init 0xFFFF at DI; no final XOR.
- pkt_done and crc_err are registered 1 cycle after the CRCH byte.

Counters:
- frame_start: line_count<=0, frame_count+1.
- line_count increments at pkt_done for VC-matched long packets, regardless of crc_err.

Boundaries:
- byte_valid=0 in any state other than IDLE: pkt_err pulse, go to IDLE, no pkt_done. This includes the cycle after ECC when a long packet is expected.
- sot=1 outside IDLE: pkt_err pulse. The byte is taken as a new DI and the state goes to WCL with CRC re-initialised.
- enable falling mid-packet: go to IDLE immediately, no pulses. Counters are held.
- frame_count wraps; line_count saturates at 0xFFFF.
- Asynchronous reset mid-packet: all state and outputs are cleared immediately.

Test Plan:
- Short FS: sot+{00,00,00,ECC}, then FE {01,00,00,ECC} -> one frame_start pulse, frame_count=1, line_count=0; then one frame_end pulse.
- Long packet, VC0 DT 0x2B, WC=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, CRC bytes F0 00 -> 24 pix_valid bytes in order, each 1 cycle after input; pkt_done=1, crc_err=0, word_count=0x0018, data_type=0x2B, line_count=1.
- Same packet with CRC bytes F1 00 -> pkt_done=1, crc_err=1, line_count still increments.
- byte_valid drops after payload byte 10 -> pkt_err pulse, no pkt_done, state IDLE. The next sot packet parses correctly.
- VC=1 long packet with VC_ID=0 -> no pix_valid, no pkt_done, no line_count change. WC=0x2000 with MAX_WC=4096 -> pkt_err.
- enable=0 while sending an FS packet -> no outputs. Assert rstn=0 mid-payload -> all outputs 0 immediately.
